spell_commit: RTL and testbench
===============================

Name: spell_commit

Overview:
- Back end of the spell execute stage: accepts one result bundle per instruction from spell_execute and applies it.
- Applies pc/sp updates and stack writes, issues memory writes over a req/ack handshake, and runs delay/sleep stalls.
- Owns the 32x8 stack register file; drives the stack_top/stack_belowtop read ports that feed spell_execute.
- Sits between spell_execute and the data/code/IO memory arbiter.

Parameters:
- DELAY_SHIFT, 4, one delay_amount unit = 2^DELAY_SHIFT clocks
- STACK_DEPTH_BITS, 5, stack address width (32 entries)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- exec_valid  input  1  result bundle valid this cycle
- exec_ready  output  1  commit can accept a bundle
- next_pc  input  8  pc after this instruction
- next_sp  input  5  sp after this instruction
- stack_write_count  input  2  number of stack entries to write (0..2)
- set_stack_top  input  8  value for stack[next_sp-1]
- set_stack_belowtop  input  8  value for stack[next_sp-2]
- memory_write_type  input  2  0 none, 1 data, 2 code, 3 io
- memory_write_addr  input  8  write address
- memory_write_data  input  8  write data
- delay_amount  input  8  delay units; 0 = no delay
- sleep  input  1  enter sleep after commit
- wake  input  1  leave sleep
- pc  output  8  architectural pc
- sp  output  5  architectural sp
- stack_top  output  8  stack[sp-1], combinational read
- stack_belowtop  output  8  stack[sp-2], combinational read
- mem_req  output  1  memory write request
- mem_type  output  2  registered memory_write_type
- mem_addr  output  8  registered address
- mem_data  output  8  registered data
- mem_ack  input  1  memory write accepted
- busy  output  1  state != IDLE

Behaviour:
- Reset: pc=0, sp=0, all 32 stack entries=0, mem_req=0, mem_type=0, mem_addr=0, mem_data=0, busy=0, exec_ready=1, state=IDLE, delay counter=0.
- States: IDLE, MEM, DELAY, SLEEP. exec_ready = (state==IDLE) && !reset.
- Commit occurs on a rising edge with exec_valid && exec_ready. Same edge:
  - pc<=next_pc, sp<=next_sp.
  - count>=1: stack[next_sp-1]<=set_stack_top.
  - count==2: also stack[next_sp-2]<=set_stack_belowtop.
  - count==3 is treated as 2.
- Stack indices are 5-bit modulo arithmetic: next_sp=0 writes entries 31 and 30; next_sp=1 with count 2 writes entries 0 and 31.
- Next state after commit, in priority order:
  - memory_write_type!=0: MEM. Latch mem_type/addr/data; mem_req=1 from the next cycle.
  - else delay_amount!=0: DELAY.
  - else sleep: SLEEP.
  - else IDLE.
- MEM:
  - mem_req and the mem_* outputs stay stable until the first cycle mem_ack=1.
  - On that edge mem_req<=0, then DELAY if the latched delay is nonzero, else SLEEP if latched sleep, else IDLE.
  - mem_ack while mem_req=0 is ignored.
- DELAY:
  - Counter loaded with delay_amount<<DELAY_SHIFT (16-bit) at commit, or on MEM exit.
  - Decrements once per clock; when it reaches 1, go to SLEEP if latched sleep, else IDLE.
  - Stall length = delay_amount*2^DELAY_SHIFT cycles exactly (255 units -> 4080 cycles).
- SLEEP: stays until wake=1, then IDLE on that edge. A wake sampled in any other state is ignored.
- Read ports reflect registered sp and stack contents. A value written at commit is visible the cycle after commit.
- Reset in any state, including mid-MEM, aborts immediately to the reset values. The pending write is dropped (mem_req=0 next cycle).
- exec_valid while exec_ready=0: bundle ignored, no state change. spell_execute must hold it.

Test Plan:
- Reset, sp=0; commit next_sp=2, count=2, top=10, belowtop=15 -> sp=2, stack_top=10, stack_belowtop=15 on the next cycle; exec_ready stays 1.
- Commit with next_sp=1, count=2, top=0xAA, belowtop=0xBB -> stack[0]=0xAA, stack[31]=0xBB (wrap); sp=1.
- Commit type=1, addr=0x42, data=0x7E; hold mem_ack=0 for 3 cycles then 1 -> mem_req high exactly 4 cycles with addr/data stable, exec_ready=0 throughout, IDLE the cycle after ack.
- Commit delay_amount=3 with DELAY_SHIFT=4 -> exec_ready low exactly 48 cycles; same test with delay_amount=0 -> no stall.
- Commit type=3, delay_amount=1, sleep=1 -> order MEM -> DELAY(16 cycles) -> SLEEP; wake pulse returns to IDLE; a wake pulse during DELAY has no effect.
- Assert reset while in MEM with mem_req=1 -> next cycle mem_req=0, pc=0, sp=0, stack_top=0, exec_ready=1.

Source files
------------

// File: rtl/spell_commit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spell_commit
//  Description : Commit back end of the spell execute stage. Accepts one
//                result bundle per instruction, updates pc/sp and the 32x8
//                stack register file, issues memory writes over a req/ack
//                handshake, then runs the delay and sleep stalls.
//  Ports       : clock/reset             - clock, synchronous active-high reset
//                exec_valid/exec_ready   - result bundle handshake
//                next_pc..sleep          - result bundle fields
//                wake                    - leave sleep
//                pc/sp                   - architectural state
//                stack_top/belowtop      - combinational stack read ports
//                mem_req/type/addr/data  - registered memory write request
//                mem_ack                 - memory write accepted
//                busy                    - stage is stalling (not idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module spell_commit #(
    parameter int DELAY_SHIFT      = 4,
    parameter int STACK_DEPTH_BITS = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        exec_valid,
    output logic                        exec_ready,
    input  logic [7:0]                  next_pc,
    input  logic [STACK_DEPTH_BITS-1:0] next_sp,
    input  logic [1:0]                  stack_write_count,
    input  logic [7:0]                  set_stack_top,
    input  logic [7:0]                  set_stack_belowtop,
    input  logic [1:0]                  memory_write_type,
    input  logic [7:0]                  memory_write_addr,
    input  logic [7:0]                  memory_write_data,
    input  logic [7:0]                  delay_amount,
    input  logic                        sleep,
    input  logic                        wake,
    output logic [7:0]                  pc,
    output logic [STACK_DEPTH_BITS-1:0] sp,
    output logic [7:0]                  stack_top,
    output logic [7:0]                  stack_belowtop,
    output logic                        mem_req,
    output logic [1:0]                  mem_type,
    output logic [7:0]                  mem_addr,
    output logic [7:0]                  mem_data,
    input  logic                        mem_ack,
    output logic                        busy
);

    localparam int c_DEPTH = 1 << STACK_DEPTH_BITS;
    localparam logic [STACK_DEPTH_BITS-1:0] c_ONE = STACK_DEPTH_BITS'(1);
    localparam logic [STACK_DEPTH_BITS-1:0] c_TWO = STACK_DEPTH_BITS'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEM   = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;
    localparam logic [1:0] S_SLEEP = 2'd3;

    logic [1:0]                  r_state;
    logic [1:0]                  w_next_state;
    logic [7:0]                  r_pc;
    logic [STACK_DEPTH_BITS-1:0] r_sp;
    logic [7:0]                  r_stack [c_DEPTH];
    logic                        r_mem_req;
    logic [1:0]                  r_mem_type;
    logic [7:0]                  r_mem_addr;
    logic [7:0]                  r_mem_data;
    logic [7:0]                  r_delay_lat;
    logic                        r_sleep_lat;
    logic [15:0]                 r_delay_cnt;

    logic                        w_commit;
    logic                        w_mem_done;
    logic [7:0]                  w_delay_src;
    logic [15:0]                 w_delay_load;
    logic [STACK_DEPTH_BITS-1:0] w_wr_top_idx;
    logic [STACK_DEPTH_BITS-1:0] w_wr_below_idx;

    assign w_commit   = exec_valid && exec_ready;
    // mem_req is always set while in MEM; the check keeps stray acks inert
    assign w_mem_done = (r_state == S_MEM) && r_mem_req && mem_ack;

    // Delay comes from the bundle at commit, or from the latched copy on MEM exit
    assign w_delay_src  = w_commit ? delay_amount : r_delay_lat;
    assign w_delay_load = {8'd0, w_delay_src} << DELAY_SHIFT;

    // 5-bit wraparound: next_sp=0 targets entries 31/30
    assign w_wr_top_idx   = next_sp - c_ONE;
    assign w_wr_below_idx = next_sp - c_TWO;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    if (memory_write_type != 2'd0) begin
                        w_next_state = S_MEM;
                    end else if (delay_amount != 8'd0) begin
                        w_next_state = S_DELAY;
                    end else if (sleep) begin
                        w_next_state = S_SLEEP;
                    end
                end
            end
            S_MEM: begin
                if (w_mem_done) begin
                    if (r_delay_lat != 8'd0) begin
                        w_next_state = S_DELAY;
                    end else if (r_sleep_lat) begin
                        w_next_state = S_SLEEP;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DELAY: begin
                // Counter starts at N and the last stall cycle is the one at 1
                if (r_delay_cnt == 16'd1) begin
                    w_next_state = r_sleep_lat ? S_SLEEP : S_IDLE;
                end
            end
            S_SLEEP: begin
                if (wake) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        exec_ready = (r_state == S_IDLE) && !reset;
        busy       = (r_state != S_IDLE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc        <= 8'd0;
            r_sp        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_type  <= 2'd0;
            r_mem_addr  <= 8'd0;
            r_mem_data  <= 8'd0;
            r_delay_lat <= 8'd0;
            r_sleep_lat <= 1'b0;
            r_delay_cnt <= 16'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_stack[i] <= 8'd0;
            end
        end else begin
            if (w_commit) begin
                r_pc        <= next_pc;
                r_sp        <= next_sp;
                r_delay_lat <= delay_amount;
                r_sleep_lat <= sleep;
                // A count of 3 behaves as 2: bit 1 alone selects the second write
                if (stack_write_count != 2'd0) begin
                    r_stack[w_wr_top_idx] <= set_stack_top;
                end
                if (stack_write_count[1]) begin
                    r_stack[w_wr_below_idx] <= set_stack_belowtop;
                end
                if (memory_write_type != 2'd0) begin
                    r_mem_req  <= 1'b1;
                    r_mem_type <= memory_write_type;
                    r_mem_addr <= memory_write_addr;
                    r_mem_data <= memory_write_data;
                end
            end

            if (w_mem_done) begin
                r_mem_req <= 1'b0;
            end

            if (w_commit || w_mem_done) begin
                r_delay_cnt <= w_delay_load;
            end else if (r_state == S_DELAY) begin
                r_delay_cnt <= r_delay_cnt - 16'd1;
            end
        end
    end

    assign pc             = r_pc;
    assign sp             = r_sp;
    assign stack_top      = r_stack[r_sp - c_ONE];
    assign stack_belowtop = r_stack[r_sp - c_TWO];
    assign mem_req        = r_mem_req;
    assign mem_type       = r_mem_type;
    assign mem_addr       = r_mem_addr;
    assign mem_data       = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_spell_commit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spell_commit
//  Description : Self-checking bench for spell_commit: directed vector table,
//                randomized bundles against a transaction-level model, and a
//                mid-MEM reset sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spell_commit;

    localparam int LIMIT = 6000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       exec_valid = 1'b0;
    logic       exec_ready;
    logic [7:0] next_pc = '0;
    logic [4:0] next_sp = '0;
    logic [1:0] stack_write_count = '0;
    logic [7:0] set_stack_top = '0;
    logic [7:0] set_stack_belowtop = '0;
    logic [1:0] memory_write_type = '0;
    logic [7:0] memory_write_addr = '0;
    logic [7:0] memory_write_data = '0;
    logic [7:0] delay_amount = '0;
    logic       sleep = 1'b0;
    logic       wake = 1'b0;
    logic [7:0] pc;
    logic [4:0] sp;
    logic [7:0] stack_top;
    logic [7:0] stack_belowtop;
    logic       mem_req;
    logic [1:0] mem_type;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_ack = 1'b0;
    logic       busy;

    spell_commit #(.DELAY_SHIFT(4), .STACK_DEPTH_BITS(5)) dut (
        .clock(clock), .reset(reset),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .next_pc(next_pc), .next_sp(next_sp),
        .stack_write_count(stack_write_count),
        .set_stack_top(set_stack_top), .set_stack_belowtop(set_stack_belowtop),
        .memory_write_type(memory_write_type),
        .memory_write_addr(memory_write_addr),
        .memory_write_data(memory_write_data),
        .delay_amount(delay_amount), .sleep(sleep), .wake(wake),
        .pc(pc), .sp(sp), .stack_top(stack_top), .stack_belowtop(stack_belowtop),
        .mem_req(mem_req), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] npc;
        logic [4:0] nsp;
        logic [1:0] cnt;
        logic [7:0] top;
        logic [7:0] below;
        logic [1:0] mtype;
        logic [7:0] maddr;
        logic [7:0] mdata;
        logic [7:0] dly;
        logic       slp;
        int         ack_wait;   // cycle index (after commit) at which ack is raised
        int         wake_at;    // cycle index of the real wake pulse, -1 none
        int         glitch_at;  // cycle index of a wake pulse that must be ignored
        int         exp_stall;
        int         exp_req;
        logic [7:0] exp_top;
        logic [7:0] exp_below;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural state only
    logic [7:0] m_stack [32];
    logic [7:0] m_pc;
    logic [4:0] m_sp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_stack[k] = 8'd0;
        m_pc = 8'd0;
        m_sp = 5'd0;
    endtask

    task automatic model_commit(input vec_t v);
        logic [4:0] ix;
        m_pc = v.npc;
        m_sp = v.nsp;
        if (v.cnt >= 2'd1) begin
            ix = v.nsp - 5'd1;
            m_stack[ix] = v.top;
        end
        if (v.cnt >= 2'd2) begin
            ix = v.nsp - 5'd2;
            m_stack[ix] = v.below;
        end
    endtask

    // Commits one bundle, then drives ack/wake and counts the cycles exec_ready stays low.
    task automatic run_vec(input vec_t v, output int stall, output int reqc, output int unstable);
        int i;
        i = 0;
        while (!exec_ready && i < 100) begin
            @(posedge clock); #1; i++;
        end
        chk("ready_before_commit", {31'd0, exec_ready}, 32'd1);
        next_pc = v.npc; next_sp = v.nsp; stack_write_count = v.cnt;
        set_stack_top = v.top; set_stack_belowtop = v.below;
        memory_write_type = v.mtype; memory_write_addr = v.maddr;
        memory_write_data = v.mdata; delay_amount = v.dly; sleep = v.slp;
        exec_valid = 1'b1;
        @(posedge clock); #1;
        exec_valid = 1'b0;
        model_commit(v);
        i = 0; reqc = 0; unstable = 0;
        while (!exec_ready && i < LIMIT) begin
            if (mem_req) begin
                reqc++;
                if ({mem_type, mem_addr, mem_data} !== {v.mtype, v.maddr, v.mdata}) unstable++;
            end
            if (v.mtype != 2'd0 && i == v.ack_wait)
                mem_ack = 1'b1;
            else if (v.mtype == 2'd0 || i > v.ack_wait)
                mem_ack = 1'($urandom_range(0, 1));   // stray acks must be ignored
            else
                mem_ack = 1'b0;
            wake = (i == v.wake_at) || (i == v.glitch_at);
            // Garbage bundles offered while stalled must be ignored
            exec_valid = 1'($urandom_range(0, 1));
            next_pc = 8'($urandom); next_sp = 5'($urandom);
            stack_write_count = 2'($urandom); set_stack_top = 8'($urandom);
            set_stack_belowtop = 8'($urandom); memory_write_type = 2'($urandom);
            delay_amount = 8'($urandom); sleep = 1'($urandom);
            @(posedge clock); #1; i++;
        end
        exec_valid = 1'b0; mem_ack = 1'b0; wake = 1'b0;
        stall = i;
    endtask

    task automatic check_result(input vec_t v, input int stall, input int reqc, input int unstable,
                                input logic [7:0] etop, input logic [7:0] ebelow);
        chk("stall_cycles", stall, v.exp_stall);
        chk("mem_req_cycles", reqc, v.exp_req);
        chk("mem_fields_stable", unstable, 0);
        chk("pc", {24'd0, pc}, {24'd0, v.npc});
        chk("sp", {27'd0, sp}, {27'd0, v.nsp});
        chk("stack_top", {24'd0, stack_top}, {24'd0, etop});
        chk("stack_belowtop", {24'd0, stack_belowtop}, {24'd0, ebelow});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        int   stall, reqc, unstable, pre;

        //       npc    nsp   cnt   top    below  mt    addr   data   dly    slp  ackw wake glit stall req etop   ebelow
        tbl[0] = '{8'h01, 5'd2, 2'd2, 8'h0A, 8'h0F, 2'd0, 8'h00, 8'h00, 8'd0,   1'b0, 0, -1, -1, 0,    0, 8'h0A, 8'h0F};
        tbl[1] = '{8'h02, 5'd1, 2'd2, 8'hAA, 8'hBB, 2'd0, 8'h00, 8'h00, 8'd0,   1'b0, 0, -1, -1, 0,    0, 8'hAA, 8'hBB};
        tbl[2] = '{8'h03, 5'd1, 2'd0, 8'hC1, 8'hC2, 2'd1, 8'h42, 8'h7E, 8'd0,   1'b0, 3, -1, -1, 4,    4, 8'hAA, 8'hBB};
        tbl[3] = '{8'h04, 5'd4, 2'd3, 8'h11, 8'h22, 2'd0, 8'h00, 8'h00, 8'd3,   1'b0, 0, -1, 10, 48,   0, 8'h11, 8'h22};
        tbl[4] = '{8'h05, 5'd0, 2'd1, 8'h33, 8'h44, 2'd0, 8'h00, 8'h00, 8'd0,   1'b0, 0, -1, -1, 0,    0, 8'h33, 8'h00};
        tbl[5] = '{8'h06, 5'd2, 2'd0, 8'h00, 8'h00, 2'd3, 8'h90, 8'h5A, 8'd1,   1'b1, 0, 20,  8, 21,   1, 8'h0A, 8'hAA};
        tbl[6] = '{8'h07, 5'd4, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'd255, 1'b0, 0, -1, -1, 4080, 0, 8'h11, 8'h22};
        tbl[7] = '{8'hFF, 5'd31, 2'd2, 8'h55, 8'h66, 2'd2, 8'hFF, 8'h00, 8'd0,  1'b1, 0,  2, -1, 3,    1, 8'h55, 8'h66};

        // ---------------- reset ----------------
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("ready_low_in_reset", {31'd0, exec_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_sp", {27'd0, sp}, 32'd0);
        chk("rst_top", {24'd0, stack_top}, 32'd0);
        chk("rst_below", {24'd0, stack_belowtop}, 32'd0);
        chk("rst_mem", {15'd0, mem_req, mem_type, mem_addr, mem_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, exec_ready}, 32'd1);

        // ---------------- directed table ----------------
        for (int t = 0; t < 8; t++) begin
            run_vec(tbl[t], stall, reqc, unstable);
            check_result(tbl[t], stall, reqc, unstable, tbl[t].exp_top, tbl[t].exp_below);
        end

        // ---------------- randomized against model ----------------
        for (int n = 0; n < 40; n++) begin
            v.npc   = 8'($urandom);
            v.nsp   = 5'($urandom);
            v.cnt   = 2'($urandom);
            v.top   = 8'($urandom);
            v.below = 8'($urandom);
            v.mtype = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.maddr = 8'($urandom);
            v.mdata = 8'($urandom);
            v.dly   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 5)) : 8'd0;
            v.slp   = ($urandom_range(0, 4) == 0);
            v.ack_wait = int'($urandom_range(0, 4));
            pre = ((v.mtype != 2'd0) ? v.ack_wait + 1 : 0) + int'(v.dly) * 16;
            v.glitch_at = (pre > 0) ? int'($urandom_range(0, pre - 1)) : -1;
            if (v.slp) begin
                v.wake_at   = pre + int'($urandom_range(0, 3));
                v.exp_stall = v.wake_at + 1;
            end else begin
                v.wake_at   = -1;
                v.exp_stall = pre;
            end
            v.exp_req = (v.mtype != 2'd0) ? v.ack_wait + 1 : 0;
            run_vec(v, stall, reqc, unstable);
            check_result(v, stall, reqc, unstable, m_stack[m_sp - 5'd1], m_stack[m_sp - 5'd2]);
        end

        // ---------------- reset while a memory write is pending ----------------
        next_pc = 8'h3C; next_sp = 5'd5; stack_write_count = 2'd2;
        set_stack_top = 8'hE1; set_stack_belowtop = 8'hE2;
        memory_write_type = 2'd1; memory_write_addr = 8'h12; memory_write_data = 8'h34;
        delay_amount = 8'd2; sleep = 1'b1;
        chk("ready_before_rst_seq", {31'd0, exec_ready}, 32'd1);
        exec_valid = 1'b1;
        @(posedge clock); #1;
        exec_valid = 1'b0;
        @(posedge clock); #1;
        chk("mem_req_pending", {31'd0, mem_req}, 32'd1);
        chk("ready_low_in_mem", {31'd0, exec_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", {24'd0, pc}, 32'd0);
        chk("abort_sp", {27'd0, sp}, 32'd0);
        chk("abort_top", {24'd0, stack_top}, 32'd0);
        chk("abort_below", {24'd0, stack_belowtop}, 32'd0);
        chk("abort_ready", {31'd0, exec_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        // Write dropped: holding ack must not resurrect a request
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        chk("abort_stays_idle", {30'd0, mem_req, exec_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
